// File: rtl/reg_fifo_pkg.sv
// -----------------------------------------------------------------------------
// reg_fifo_pkg
//   Shared defaults and helpers for the register-based FIFO.
//   DEF_WIDTH   : default data word width
//   DEF_DEPTH   : default number of storage entries
//   DEF_COUNT_W : default width of the occupancy count
//   next_ptr()  : pointer increment with explicit wrap at depth-1, so depths
//                 that are not powers of two wrap correctly
// -----------------------------------------------------------------------------
package reg_fifo_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_DEPTH   = 16;
   localparam int DEF_COUNT_W = 6;

   function automatic logic [31:0] next_ptr(input logic [31:0] ptr, input int depth_i);
      return (ptr == 32'(depth_i - 1)) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/reg_fifo_if.sv
// -----------------------------------------------------------------------------
// reg_fifo_if
//   Producer/consumer bus of the register FIFO.
//   data_in  : write data            w_en  : write request
//   r_en     : read request          data_out : registered read data
//   empty    : no stored entries     full  : depth entries stored
//   count_1  : current occupancy
//   master modport : the side driving requests (producer/consumer)
//   slave  modport : the FIFO itself
// -----------------------------------------------------------------------------
interface reg_fifo_if
   import reg_fifo_pkg::*;
#(
   parameter int width       = DEF_WIDTH,
   parameter int count_width = DEF_COUNT_W
);

   logic [width-1:0]       data_in;
   logic                   w_en;
   logic                   r_en;
   logic [width-1:0]       data_out;
   logic                   empty;
   logic                   full;
   logic [count_width-1:0] count_1;

   modport master (
      output data_in, w_en, r_en,
      input  data_out, empty, full, count_1
   );

   modport slave (
      input  data_in, w_en, r_en,
      output data_out, empty, full, count_1
   );

endinterface

// File: rtl/reg_fifo.sv
// -----------------------------------------------------------------------------
// reg_fifo
//   Single-clock register-array FIFO with a registered read port.
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears pointers, count and data_out
//   bus   : reg_fifo_if.slave (data_in, w_en, r_en in; data_out, empty,
//           full, count_1 out)
//   Requests are qualified internally: writes to a full FIFO are dropped
//   unless a read happens in the same cycle, reads of an empty FIFO are
//   ignored (no write-to-read bypass). Read data appears one cycle after
//   an accepted read and holds otherwise.
// -----------------------------------------------------------------------------
module reg_fifo
   import reg_fifo_pkg::*;
#(
   parameter int width       = DEF_WIDTH,
   parameter int depth       = DEF_DEPTH,
   parameter int count_width = DEF_COUNT_W
) (
   input  logic      clk,
   input  logic      reset,
   reg_fifo_if.slave bus
);

   localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;

   logic [width-1:0]       mem_q [0:depth-1];

   logic [PTR_W-1:0]       wr_ptr_q,   wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q,   rd_ptr_d;
   logic [count_width-1:0] count_q,    count_d;
   logic [width-1:0]       data_out_q, data_out_d;

   logic wr_acc;
   logic rd_acc;
   logic empty;
   logic full;

   // Flags decode from the registered count only.
   assign empty = (count_q == '0);
   assign full  = (count_q == count_width'(depth));

   always_comb begin
      // A full FIFO still accepts a write when a read frees the oldest slot
      // in the same cycle; the read returns that oldest word.
      wr_acc     = bus.w_en & (~full | bus.r_en);
      rd_acc     = bus.r_en & ~empty;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;

      if (wr_acc) begin
         wr_ptr_d = PTR_W'(next_ptr(32'(wr_ptr_q), depth));
      end
      if (rd_acc) begin
         rd_ptr_d   = PTR_W'(next_ptr(32'(rd_ptr_q), depth));
         data_out_d = mem_q[rd_ptr_q];
      end

      count_d = count_q + count_width'(wr_acc) - count_width'(rd_acc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         data_out_q <= data_out_d;
      end
   end

   // Storage is not cleared by reset; a reset cycle blocks the write so a
   // stale request cannot land in the array.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem_q[wr_ptr_q] <= bus.data_in;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.empty    = empty;
   assign bus.full     = full;
   assign bus.count_1  = count_q;

endmodule

// File: tb/tb_reg_fifo.sv
// -----------------------------------------------------------------------------
// tb_reg_fifo
//   Directed bench for reg_fifo (width 32, depth 16, count_width 6).
//   A reference queue holds the stored words; words returned by accepted
//   reads are pushed to a scoreboard and popped when data_out is sampled.
// -----------------------------------------------------------------------------
module tb_reg_fifo;

   localparam int WIDTH   = 32;
   localparam int DEPTH   = 16;
   localparam int COUNT_W = 6;

   logic clk;
   logic reset;

   reg_fifo_if #(.width(WIDTH), .count_width(COUNT_W)) bus ();

   reg_fifo #(
      .width       (WIDTH),
      .depth       (DEPTH),
      .count_width (COUNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned       n_assert;
   int unsigned       n_fail;
   logic [WIDTH-1:0]  mdl_q [$];   // words the FIFO should hold
   logic [WIDTH-1:0]  sb_q  [$];   // words an accepted read should return
   logic [WIDTH-1:0]  exp_dout;

   task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of requests, update the reference, wait past the edge
   // and compare every output at the falling edge.
   task automatic step(input bit w, input bit r, input logic [WIDTH-1:0] d, input bit rst);
      bit m_full;
      bit m_empty;
      bit wa;
      bit ra;
      reset       = rst;
      bus.w_en    = w;
      bus.r_en    = r;
      bus.data_in = d;
      m_full  = (mdl_q.size() == DEPTH);
      m_empty = (mdl_q.size() == 0);
      if (rst) begin
         mdl_q.delete();
         sb_q.delete();
         exp_dout = '0;
      end else begin
         wa = w && (!m_full || r);
         ra = r && !m_empty;
         if (ra) sb_q.push_back(mdl_q.pop_front());
         if (wa) mdl_q.push_back(d);
      end
      @(posedge clk);
      @(negedge clk);
      if (sb_q.size() > 0) exp_dout = sb_q.pop_front();
      chk("data_out", bus.data_out, exp_dout);
      chk("count_1",  WIDTH'(bus.count_1), WIDTH'(mdl_q.size()));
      chk("empty",    WIDTH'(bus.empty),   WIDTH'(mdl_q.size() == 0));
      chk("full",     WIDTH'(bus.full),    WIDTH'(mdl_q.size() == DEPTH));
   endtask

   initial begin
      n_assert    = 0;
      n_fail      = 0;
      exp_dout    = '0;
      reset       = 1'b1;
      bus.w_en    = 1'b0;
      bus.r_en    = 1'b0;
      bus.data_in = '0;

      // Reset for two cycles
      step(0, 0, 32'd0, 1);
      step(0, 0, 32'd0, 1);
      chk("rst_count", WIDTH'(bus.count_1), 32'd0);
      chk("rst_empty", WIDTH'(bus.empty),   32'd1);
      chk("rst_full",  WIDTH'(bus.full),    32'd0);
      chk("rst_dout",  bus.data_out,        32'd0);

      // Overfill: 32 writes, one per two cycles; last 16 dropped
      for (int i = 0; i < 32; i++) begin
         step(1, 0, 32'(i), 0);
         step(0, 0, 32'd0, 0);
         if (i == 15) chk("fill_full16", WIDTH'(bus.full), 32'd1);
      end
      chk("overfill_count", WIDTH'(bus.count_1), 32'd16);

      // Drain with 32 back-to-back reads
      for (int i = 0; i < 32; i++) begin
         step(0, 1, 32'd0, 0);
         if (i < 16) chk("drain_order", bus.data_out, 32'(i));
      end
      chk("drain_hold", bus.data_out, 32'd15);
      chk("drain_count", WIDTH'(bus.count_1), 32'd0);

      // Simultaneous read/write on empty: write only, no bypass
      step(1, 1, 32'd0, 0);
      chk("sim_empty_count", WIDTH'(bus.count_1), 32'd1);
      chk("sim_empty_dout",  bus.data_out, 32'd15);
      step(1, 1, 32'd1, 0);
      chk("sim_mid_dout",  bus.data_out, 32'd0);
      chk("sim_mid_count", WIDTH'(bus.count_1), 32'd1);
      step(0, 1, 32'd0, 0);

      // Simultaneous read/write on full
      for (int i = 0; i < DEPTH; i++) step(1, 0, 32'(i), 0);
      step(1, 1, 32'd99, 0);
      chk("sim_full_dout",  bus.data_out, 32'd0);
      chk("sim_full_count", WIDTH'(bus.count_1), 32'd16);
      for (int i = 0; i < DEPTH; i++) step(0, 1, 32'd0, 0);
      chk("sim_full_last", bus.data_out, 32'd99);

      // Mid-operation reset with a read request pending
      step(1, 0, 32'd23, 0);
      step(0, 1, 32'd0, 1);
      chk("midrst_count", WIDTH'(bus.count_1), 32'd0);
      chk("midrst_dout",  bus.data_out, 32'd0);
      step(1, 0, 32'd13, 0);
      step(0, 1, 32'd0, 0);
      chk("midrst_read", bus.data_out, 32'd13);

      // Mixed random traffic against the reference queue
      for (int i = 0; i < 300; i++) begin
         step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
